regfile_arbiter: RTL and testbench

- Two-requester controller that shares one 4-entry × 8-bit, two-port register file.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. Accepted writes go to the register-file write port. Reads are sequenced through the file's 1-cycle registered read address.
- Sits between two client engines and the register file. Does not reset the file's contents.

---
 rtl/regfile_arbiter_if.sv | 25 ++
 rtl/regfile_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// One requester's request/response channel into regfile_arbiter.
// master = client engine side, slave = arbiter side.
interface regfile_arbiter_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_write, req_addr, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one two-port register file between requesters A and B.
// Optional macro REGFILE_ARB_WRITE_ACK_EN: writes also return a response carrying the write data.
module regfile_arbiter #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   regfile_arbiter_if.slave      a,
   regfile_arbiter_if.slave      b,
   output logic                  rf_write_en,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic [ADDR_WIDTH-1:0] rf_read_address,
   input  logic [DATA_WIDTH-1:0] rf_read_data
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

   state_t                state, state_nxt;
   req_t                  owner, owner_nxt;
   req_t                  prio, prio_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
   logic [DATA_WIDTH-1:0] rsp_q, rsp_q_nxt;

   req_t                  grant;
   logic                  accept;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt        = state;
      owner_nxt        = owner;
      prio_nxt         = prio;
      rd_addr_nxt      = rd_addr;
      rsp_q_nxt        = rsp_q;
      rf_write_en      = 1'b0;
      rf_write_address = '0;
      rf_write_data    = '0;
      rf_read_address  = '0;

      // Grant only exists in IDLE and never while reset is held.
      accept    = !reset && (state == IDLE) && (a.req_valid || b.req_valid);
      grant     = (a.req_valid && b.req_valid) ? prio : (b.req_valid ? REQ_B : REQ_A);
      sel_write = (grant == REQ_B) ? b.req_write : a.req_write;
      sel_addr  = (grant == REQ_B) ? b.req_addr  : a.req_addr;
      sel_data  = (grant == REQ_B) ? b.req_data  : a.req_data;

      a.req_ready = accept && (grant == REQ_A);
      b.req_ready = accept && (grant == REQ_B);

      a.rsp_valid = !reset && (state == RSP) && (owner == REQ_A);
      b.rsp_valid = !reset && (state == RSP) && (owner == REQ_B);
      a.rsp_data  = a.rsp_valid ? rsp_q : '0;
      b.rsp_data  = b.rsp_valid ? rsp_q : '0;

      if (!reset) begin
         rf_read_address = (state == IDLE) ? (accept ? sel_addr : '0) : rd_addr;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               prio_nxt = (grant == REQ_A) ? REQ_B : REQ_A;
               if (sel_write) begin
                  rf_write_en      = 1'b1;
                  rf_write_address = sel_addr;
                  rf_write_data    = sel_data;
`ifdef REGFILE_ARB_WRITE_ACK_EN
                  owner_nxt = grant;
                  rsp_q_nxt = sel_data;
                  state_nxt = RSP;
`endif
               end else begin
                  owner_nxt   = grant;
                  rd_addr_nxt = sel_addr;
                  state_nxt   = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // The file registered the address last cycle; its data is valid now.
            rsp_q_nxt = rf_read_data;
            state_nxt = RSP;
         end
         RSP: begin
            if ((owner == REQ_A) ? a.rsp_ready : b.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The register file lives outside this block and keeps its contents across reset;
   // only control state and the response holding register are cleared here.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state   <= IDLE;
         owner   <= REQ_A;
         prio    <= REQ_A;
         rd_addr <= '0;
         rsp_q   <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         prio    <= prio_nxt;
         rd_addr <= rd_addr_nxt;
         rsp_q   <= rsp_q_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: register-file model, shadow contents and a response scoreboard.
// Build with REGFILE_ARB_WRITE_ACK_EN defined to also cover acknowledged writes.
module tb_regfile_arbiter;

   typedef struct packed {
      logic       who;
      logic [7:0] data;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       rf_write_en;
   logic [1:0] rf_write_address;
   logic [7:0] rf_write_data;
   logic [1:0] rf_read_address;
   logic [7:0] rf_read_data;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [7:0] exp_mem [4];

   logic       pa_v, pa_hs, pb_v, pb_hs;
   logic [7:0] pa_d, pb_d;

   regfile_arbiter_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) a_bus ();
   regfile_arbiter_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) b_bus ();

   regfile_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .a                (a_bus),
      .b                (b_bus),
      .rf_write_en      (rf_write_en),
      .rf_write_address (rf_write_address),
      .rf_write_data    (rf_write_data),
      .rf_read_address  (rf_read_address),
      .rf_read_data     (rf_read_data)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Register file model: write port and registered read address.
   logic [7:0] rf_mem [4];
   logic [1:0] rf_raddr_q;
   always @(posedge clock) begin
      if (rf_write_en) rf_mem[rf_write_address] <= rf_write_data;
      rf_raddr_q <= rf_read_address;
   end
   assign rf_read_data = rf_mem[rf_raddr_q];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic who, input logic v, input logic w,
                        input logic [1:0] ad, input logic [7:0] d);
      if (who == 1'b0) begin
         a_bus.req_valid = v; a_bus.req_write = w; a_bus.req_addr = ad; a_bus.req_data = d;
      end else begin
         b_bus.req_valid = v; b_bus.req_write = w; b_bus.req_addr = ad; b_bus.req_data = d;
      end
   endtask

   // Present one request, wait for its accept, check the file port, push the expected response.
   task automatic issue(input logic who, input logic w, input logic [1:0] ad, input logic [7:0] d);
      logic done;
      logic hit;
      done = 1'b0;
      drive(who, 1'b1, w, ad, d);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clock);
         hit = (who == 1'b0) ? (a_bus.req_valid && a_bus.req_ready)
                             : (b_bus.req_valid && b_bus.req_ready);
         if (hit) begin
            done = 1'b1;
            if (w) begin
               check("wr_en", rf_write_en, 1);
               check("wr_addr", rf_write_address, ad);
               check("wr_data", rf_write_data, d);
               exp_mem[ad] = d;
`ifdef REGFILE_ARB_WRITE_ACK_EN
               sb.push_back('{who, d});
`endif
            end else begin
               check("rd_no_wr", rf_write_en, 0);
               check("rd_addr", rf_read_address, ad);
               sb.push_back('{who, exp_mem[ad]});
            end
         end
         @(posedge clock); #1;
      end
      drive(who, 1'b0, 1'b0, 2'd0, 8'd0);
      check("accept_timeout", done, 1);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (sb.size() != 0 && c < 60) begin
         @(negedge clock);
         c++;
      end
      check("drain_timeout", sb.size(), 0);
      @(posedge clock); #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      sb.delete();
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // Response monitor: scoreboard pops on handshake, plus hold-stable and exclusivity checks.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         pa_v = 1'b0; pb_v = 1'b0; pa_hs = 1'b0; pb_hs = 1'b0;
      end else begin
         if (a_bus.rsp_valid || b_bus.rsp_valid)
            check("rsp_exclusive", a_bus.rsp_valid & b_bus.rsp_valid, 0);
         if (pa_v && !pa_hs) begin
            check("a_hold_valid", a_bus.rsp_valid, 1);
            check("a_hold_data", a_bus.rsp_data, pa_d);
         end
         if (pb_v && !pb_hs) begin
            check("b_hold_valid", b_bus.rsp_valid, 1);
            check("b_hold_data", b_bus.rsp_data, pb_d);
         end
         if (a_bus.rsp_valid && a_bus.rsp_ready) begin
            check("a_rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("a_rsp", {1'b0, a_bus.rsp_data}, {e.who, e.data});
            end
         end
         if (b_bus.rsp_valid && b_bus.rsp_ready) begin
            check("b_rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("b_rsp", {1'b1, b_bus.rsp_data}, {e.who, e.data});
            end
         end
         pa_v = a_bus.rsp_valid; pa_hs = a_bus.rsp_ready; pa_d = a_bus.rsp_data;
         pb_v = b_bus.rsp_valid; pb_hs = b_bus.rsp_ready; pb_d = b_bus.rsp_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [1:0] order;
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h11);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      a_bus.rsp_ready = 1'b1;
      b_bus.rsp_ready = 1'b1;

      // Reset held two cycles with A requesting.
      repeat (2) begin
         @(negedge clock);
         check("rst_a_ready", a_bus.req_ready, 0);
         check("rst_a_rsp", a_bus.rsp_valid, 0);
         check("rst_b_rsp", b_bus.rsp_valid, 0);
         check("rst_wr_en", rf_write_en, 0);
         check("rst_rd_addr", rf_read_address, 0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
      @(negedge clock);
      check("prio_a_ready", a_bus.req_ready, 1);
      check("prio_b_ready", b_bus.req_ready, 0);
      check("first_wr_en", rf_write_en, 1);
      check("first_wr_addr", rf_write_address, 0);
      check("first_wr_data", rf_write_data, 8'h11);
      exp_mem[0] = 8'h11;
`ifdef REGFILE_ARB_WRITE_ACK_EN
      sb.push_back('{1'b0, 8'h11});
`endif
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
      issue(1'b1, 1'b1, 2'd1, 8'h22);
      issue(1'b0, 1'b1, 2'd3, 8'h33);
      issue(1'b0, 1'b1, 2'd2, 8'h5A);
      drain();

      // Write then read: response two cycles after accept, B never responds.
      issue(1'b0, 1'b0, 2'd2, 8'h00);
      @(negedge clock);
      check("rd_wait_a_rsp", a_bus.rsp_valid, 0);
      check("rd_wait_b_rsp", b_bus.rsp_valid, 0);
      @(negedge clock);
      check("rd_lat2_valid", a_bus.rsp_valid, 1);
      check("rd_lat2_data", a_bus.rsp_data, 8'h5A);
      check("rd_lat2_b_rsp", b_bus.rsp_valid, 0);
      @(posedge clock); #1;
      drain();

      // Contention: both hold reads, grants must alternate starting with A.
      pulse_reset();
      drive(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
      drive(1'b1, 1'b1, 1'b0, 2'd1, 8'd0);
      n = 0;
      order = 2'b00;
      for (int c = 0; c < 60 && n < 4; c++) begin
         @(negedge clock);
         if (a_bus.req_ready || b_bus.req_ready) begin
            check("grant_one_hot", a_bus.req_ready & b_bus.req_ready, 0);
            check($sformatf("grant_order_%0d", n), b_bus.req_ready, n[0]);
            if (b_bus.req_ready) sb.push_back('{1'b1, exp_mem[1]});
            else                 sb.push_back('{1'b0, exp_mem[0]});
            order = {order[0], b_bus.req_ready};
            n++;
         end
         @(posedge clock);
      end
      #1;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      check("grant_count", n, 4);
      check("grant_last_pair", order, 2'b01);
      drain();

      // Backpressure: A's response held five cycles, B waits until the handshake.
      a_bus.rsp_ready = 1'b0;
      issue(1'b0, 1'b0, 2'd3, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
      @(negedge clock);
      check("bp_b_wait_rdw", b_bus.req_ready, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("bp_a_valid", a_bus.rsp_valid, 1);
         check("bp_a_data", a_bus.rsp_data, 8'h33);
         check("bp_b_wait", b_bus.req_ready, 0);
      end
      @(posedge clock); #1;
      a_bus.rsp_ready = 1'b1;
      @(negedge clock);
      check("bp_b_wait_hs", b_bus.req_ready, 0);
      @(negedge clock);
      check("bp_b_after_hs", b_bus.req_ready, 1);
      if (b_bus.req_ready) sb.push_back('{1'b1, exp_mem[0]});
      @(posedge clock); #1;
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      drain();

      // Reset during RD_WAIT drops the read; a fresh read then completes.
      issue(1'b0, 1'b0, 2'd1, 8'h00);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      check("mid_rst_rsp", a_bus.rsp_valid, 0);
      check("mid_rst_rd_addr", rf_read_address, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("mid_rst_no_rsp", a_bus.rsp_valid | b_bus.rsp_valid, 0);
      end
      @(posedge clock); #1;
      issue(1'b0, 1'b0, 2'd1, 8'h00);
      drain();

`ifdef REGFILE_ARB_WRITE_ACK_EN
      // Acknowledged write: B's ack one cycle after accept, A waits for the handshake.
      b_bus.rsp_ready = 1'b0;
      issue(1'b1, 1'b1, 2'd3, 8'hC4);
      drive(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
      @(negedge clock);
      check("ack_b_valid", b_bus.rsp_valid, 1);
      check("ack_b_data", b_bus.rsp_data, 8'hC4);
      check("ack_a_wait", a_bus.req_ready, 0);
      @(posedge clock); #1;
      b_bus.rsp_ready = 1'b1;
      @(negedge clock);
      check("ack_a_wait_hs", a_bus.req_ready, 0);
      @(negedge clock);
      check("ack_a_after_hs", a_bus.req_ready, 1);
      if (a_bus.req_ready) sb.push_back('{1'b0, exp_mem[0]});
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
